// File: rtl/pixel_stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_seq_pkg
// Brief    : Shared types and constants for the pixel stage sequencer.
// Revision : 1.0
// ============================================================================
package pixel_seq_pkg;

  localparam int c_ADDR_W      = 18;
  localparam int c_DATA_W      = 32;
  localparam int c_STAGE_IDX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stage_sequencer_if
// Brief    : Stage handshake and shared SRAM port bundle.
// Revision : 1.0
// ============================================================================
interface pixel_stage_sequencer_if
  import pixel_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int ADDR_W     = c_ADDR_W,
  parameter int DATA_W     = c_DATA_W
);

  logic [NUM_STAGES-1:0]        stage_enable;
  logic [NUM_STAGES-1:0]        stage_done;
  logic [NUM_STAGES*ADDR_W-1:0] stage_address;
  logic [NUM_STAGES*DATA_W-1:0] stage_data_write;
  logic [NUM_STAGES-1:0]        stage_wren;
  logic [ADDR_W-1:0]            address;
  logic [DATA_W-1:0]            data_write;
  logic                         wren;

  modport master (
    output stage_enable, address, data_write, wren,
    input  stage_done, stage_address, stage_data_write, stage_wren
  );

  modport slave (
    input  stage_enable, address, data_write, wren,
    output stage_done, stage_address, stage_data_write, stage_wren
  );

endinterface
`default_nettype wire

// File: rtl/pixel_stage_sequencer_pick_next.sv
`default_nettype none
// ============================================================================
// Module   : stage_pick_next
// Brief    : Lowest-set-bit priority encoder over the pending stage mask.
// Revision : 1.0
// ============================================================================
module stage_pick_next
  import pixel_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4
) (
  input  wire logic [NUM_STAGES-1:0]    pending,
  output logic      [c_STAGE_IDX_W-1:0] index,
  output logic                          valid
);

  always_comb begin
    index = '0;
    valid = |pending;
    // Descending scan so the lowest set bit is the last to write index
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        index = c_STAGE_IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stage_sequencer
// Brief    : Runs image stages one at a time on the shared frame SRAM port.
// Revision : 1.0
// ============================================================================
module pixel_stage_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int ADDR_W     = c_ADDR_W,
  parameter int DATA_W     = c_DATA_W,
  parameter int TIMEOUT    = 1048575
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  input  wire logic                          pause,
  input  wire logic                          enable_sequence,
  input  wire logic [NUM_STAGES-1:0]         stage_mask,
  pixel_stage_sequencer_if.master            bus,
  output logic                               sequence_done,
  output logic                               sequence_error,
  output logic      [c_STAGE_IDX_W-1:0]      error_stage,
  output logic      [c_STAGE_IDX_W-1:0]      active_stage
);

  localparam int c_WD_W = $clog2(TIMEOUT + 1);

  seq_state_t                 r_state,     w_state_nxt;
  logic [NUM_STAGES-1:0]      r_pending,   w_pending_nxt;
  logic [c_STAGE_IDX_W-1:0]   r_active,    w_active_nxt;
  logic [c_WD_W-1:0]          r_wdog,      w_wdog_nxt;
  logic                       r_seq_err,   w_seq_err_nxt;
  logic [c_STAGE_IDX_W-1:0]   r_err_stage, w_err_stage_nxt;

  logic [c_STAGE_IDX_W-1:0]   w_pick_idx;
  logic                       w_pick_valid;
  logic [NUM_STAGES-1:0]      w_pick_onehot;
  logic [NUM_STAGES-1:0]      w_active_onehot;
  logic                       w_active_done;
  logic                       w_run;
  logic [ADDR_W-1:0]          w_address;
  logic [DATA_W-1:0]          w_data_write;
  logic                       w_wren;

  stage_pick_next #(
    .NUM_STAGES (NUM_STAGES)
  ) u_pick (
    .pending (r_pending),
    .index   (w_pick_idx),
    .valid   (w_pick_valid)
  );

  assign w_pick_onehot   = NUM_STAGES'(1) << w_pick_idx;
  assign w_active_onehot = NUM_STAGES'(1) << r_active;
  assign w_active_done   = |(bus.stage_done & w_active_onehot);
  assign w_run           = (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_active    <= '0;
      r_wdog      <= '0;
      r_seq_err   <= 1'b0;
      r_err_stage <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_active    <= w_active_nxt;
      r_wdog      <= w_wdog_nxt;
      r_seq_err   <= w_seq_err_nxt;
      r_err_stage <= w_err_stage_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_active_nxt    = r_active;
    w_wdog_nxt      = r_wdog;
    w_seq_err_nxt   = r_seq_err;
    w_err_stage_nxt = r_err_stage;
    if (!pause) begin
      case (r_state)
        S_IDLE: begin
          if (enable_sequence) begin
            w_pending_nxt   = stage_mask;
            w_seq_err_nxt   = 1'b0;
            w_err_stage_nxt = '0;
            w_state_nxt     = S_SCAN;
          end
        end
        S_SCAN: begin
          if (!enable_sequence) begin
            w_state_nxt = S_IDLE;
          end else if (w_pick_valid) begin
            w_active_nxt  = w_pick_idx;
            w_pending_nxt = r_pending & ~w_pick_onehot;
            w_wdog_nxt    = '0;
            w_state_nxt   = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        S_RUN: begin
          if (!enable_sequence) begin
            w_state_nxt = S_IDLE;
          end else if (w_active_done) begin
            w_state_nxt = S_DRAIN;
          end else if (r_wdog == c_WD_W'(TIMEOUT)) begin
            // A hung stage ends the whole sequence, not just its own turn
            w_seq_err_nxt   = 1'b1;
            w_err_stage_nxt = r_active;
            w_pending_nxt   = '0;
            w_state_nxt     = S_DRAIN;
          end else begin
            w_wdog_nxt = r_wdog + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!enable_sequence) begin
            w_state_nxt = S_IDLE;
          end else if (!w_active_done) begin
            w_state_nxt = S_SCAN;
          end
        end
        S_DONE: begin
          if (!enable_sequence) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Zero-latency port mux: selection depends only on registered state
  always_comb begin
    w_address    = '0;
    w_data_write = '0;
    w_wren       = 1'b0;
    if (w_run) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (r_active == c_STAGE_IDX_W'(i)) begin
          w_address    = bus.stage_address[i*ADDR_W +: ADDR_W];
          w_data_write = bus.stage_data_write[i*DATA_W +: DATA_W];
          w_wren       = bus.stage_wren[i];
        end
      end
    end
  end

  assign bus.stage_enable = (w_run && enable_sequence) ? w_active_onehot : '0;
  assign bus.address      = w_address;
  assign bus.data_write   = w_data_write;
  assign bus.wren         = w_wren;

  assign sequence_done  = (r_state == S_DONE);
  assign sequence_error = r_seq_err;
  assign error_stage    = r_err_stage;
  assign active_stage   = r_active;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stage_sequencer
// Brief    : Self-checking bench with stage models and a grant-order scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pixel_stage_sequencer;
  import pixel_seq_pkg::*;

  localparam int NS = 4;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int TO = 20;
  localparam int NEVER = 1000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pause = 1'b0;
  logic          enable_sequence = 1'b0;
  logic [NS-1:0] stage_mask = '0;
  logic          sequence_done;
  logic          sequence_error;
  logic [2:0]    error_stage;
  logic [2:0]    active_stage;

  int n_checks = 0;
  int n_errors = 0;

  pixel_stage_sequencer_if #(.NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  pixel_stage_sequencer #(
    .NUM_STAGES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pause           (pause),
    .enable_sequence (enable_sequence),
    .stage_mask      (stage_mask),
    .bus             (bus.master),
    .sequence_done   (sequence_done),
    .sequence_error  (sequence_error),
    .error_stage     (error_stage),
    .active_stage    (active_stage)
  );

  always #5 clk = ~clk;

  // Stage models: done after lat[i] enabled, unpaused cycles; done clears one cycle after enable drops
  int            lat [NS];
  int            cnt [NS];
  logic [NS-1:0] done_m;
  logic [AW-1:0] st_addr [NS];
  logic [DW-1:0] st_data [NS];
  logic [NS-1:0] wr_on;
  logic [NS-1:0] force_wr;

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (reset || !bus.stage_enable[i]) begin
        cnt[i]    <= 0;
        done_m[i] <= 1'b0;
      end else if (!pause) begin
        cnt[i] <= cnt[i] + 1;
        if (cnt[i] + 1 >= lat[i]) done_m[i] <= 1'b1;
      end
    end
  end

  assign bus.stage_done = done_m;

  genvar g;
  generate
    for (g = 0; g < NS; g++) begin : g_stage
      assign bus.stage_address[g*AW +: AW]    = st_addr[g];
      assign bus.stage_data_write[g*DW +: DW] = st_data[g];
      assign bus.stage_wren[g] = (bus.stage_enable[g] & wr_on[g]) | force_wr[g];
    end
  endgenerate

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected grant order queued at stimulus, popped on each new grant
  int            exp_q[$];
  logic [NS-1:0] prev_en = '0;

  always @(negedge clk) begin
    int k;
    int e;
    #2;
    if (!reset) begin
      if (bus.stage_enable != '0) begin
        k = 0;
        for (int i = 0; i < NS; i++) if (bus.stage_enable[i]) k = i;
        check("en_onehot", 64'($onehot(bus.stage_enable)), 64'd1);
        if (bus.stage_enable != prev_en) begin
          if (exp_q.size() == 0) begin
            check("grant_unexpected", 64'(k), 64'hFF);
          end else begin
            e = exp_q.pop_front();
            check("grant_order", 64'(k), 64'(e));
          end
        end
        check("mux_addr", 64'(bus.address), 64'(st_addr[k]));
        check("mux_data", 64'(bus.data_write), 64'(st_data[k]));
        check("mux_wren", 64'(bus.wren), 64'(wr_on[k] | force_wr[k]));
      end else begin
        check("wren_idle", 64'(bus.wren), 64'd0);
      end
    end
    prev_en = bus.stage_enable;
  end

  task automatic start_seq(input logic [NS-1:0] mask);
    stage_mask      = mask;
    enable_sequence = 1'b1;
  endtask

  task automatic stop_seq();
    enable_sequence = 1'b0;
    repeat (2) @(negedge clk);
    check("done_cleared", 64'(sequence_done), 64'd0);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!sequence_done && n < max) begin
      @(negedge clk);
      n++;
    end
    check("seq_done_reached", 64'(sequence_done), 64'd1);
  endtask

  task automatic wait_en(input int idx, input int max);
    int n = 0;
    while (!bus.stage_enable[idx] && n < max) begin
      @(negedge clk);
      n++;
    end
    check("enable_seen", 64'(bus.stage_enable[idx]), 64'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NS; i++) begin
      lat[i]     = 10;
      st_addr[i] = AW'(1000 * (i + 1));
      st_data[i] = 32'hA000_0000 + 32'(i);
    end
    wr_on    = '1;
    force_wr = '0;

    repeat (3) @(negedge clk);
    check("rst_enable", 64'(bus.stage_enable), 64'd0);
    check("rst_address", 64'(bus.address), 64'd0);
    check("rst_data", 64'(bus.data_write), 64'd0);
    check("rst_wren", 64'(bus.wren), 64'd0);
    check("rst_done", 64'(sequence_done), 64'd0);
    check("rst_error", 64'(sequence_error), 64'd0);
    check("rst_err_stage", 64'(error_stage), 64'd0);
    check("rst_active", 64'(active_stage), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Mask 1011: stages 0,1,3 in order, stage 2 skipped
    exp_q = '{0, 1, 3};
    start_seq(4'b1011);
    wait_done(300);
    check("t1_no_error", 64'(sequence_error), 64'd0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    stop_seq();

    // Empty mask goes straight to DONE
    start_seq(4'b0000);
    @(negedge clk);
    check("t2_not_yet_done", 64'(sequence_done), 64'd0);
    repeat (2) @(negedge clk);
    check("t2_done_3cyc", 64'(sequence_done), 64'd1);
    stop_seq();

    // Stage 1 hangs: watchdog aborts, stage 2 never runs
    lat[1] = NEVER;
    exp_q  = '{0, 1};
    start_seq(4'b0111);
    wait_done(300);
    check("t3_error", 64'(sequence_error), 64'd1);
    check("t3_err_stage", 64'(error_stage), 64'd1);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    stop_seq();
    lat[1] = 10;

    // Stage 0 write passes through; forced writes from idle stages are masked
    st_addr[0] = AW'(2240);
    st_data[0] = 32'hDEAD_BEEF;
    force_wr   = 4'b1110;
    exp_q      = '{0};
    start_seq(4'b0001);
    wait_en(0, 20);
    check("t4_err_cleared", 64'(sequence_error), 64'd0);
    check("t4_addr", 64'(bus.address), 64'd2240);
    check("t4_data", 64'(bus.data_write), 64'hDEAD_BEEF);
    check("t4_wren", 64'(bus.wren), 64'd1);
    wait_done(300);
    stop_seq();
    force_wr = '0;

    // Pause longer than the watchdog mid-RUN
    exp_q = '{0, 1};
    start_seq(4'b0011);
    wait_en(0, 20);
    repeat (3) @(negedge clk);
    pause = 1'b1;
    repeat (50) @(negedge clk);
    check("t5_pause_hold_en", 64'(bus.stage_enable), 64'h1);
    check("t5_pause_no_err", 64'(sequence_error), 64'd0);
    check("t5_pause_done_low", 64'(sequence_done), 64'd0);
    pause = 1'b0;
    wait_done(300);
    check("t5_no_error", 64'(sequence_error), 64'd0);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    stop_seq();

    // Abort mid-RUN of stage 2, then restart from stage 0
    exp_q = '{0, 1, 2};
    start_seq(4'b0111);
    wait_en(2, 200);
    repeat (2) @(negedge clk);
    enable_sequence = 1'b0;
    #1;
    check("t6_abort_en_drop", 64'(bus.stage_enable), 64'd0);
    @(negedge clk);
    check("t6_abort_no_done", 64'(sequence_done), 64'd0);
    check("t6_abort_active", 64'(active_stage), 64'd2);
    exp_q.delete();
    exp_q = '{0};
    start_seq(4'b0001);
    repeat (2) @(negedge clk);
    check("t6_restart_grant", 64'(bus.stage_enable), 64'h1);
    wait_done(300);
    stop_seq();

    // Reset while in DRAIN of stage 1
    exp_q = '{1};
    start_seq(4'b0010);
    n = 0;
    while (!(bus.stage_enable == '0 && done_m[1]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t7_drain_seen", 64'(done_m[1]), 64'd1);
    check("t7_active_pre", 64'(active_stage), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t7_enable", 64'(bus.stage_enable), 64'd0);
    check("t7_address", 64'(bus.address), 64'd0);
    check("t7_data", 64'(bus.data_write), 64'd0);
    check("t7_wren", 64'(bus.wren), 64'd0);
    check("t7_done", 64'(sequence_done), 64'd0);
    check("t7_error", 64'(sequence_error), 64'd0);
    check("t7_err_stage", 64'(error_stage), 64'd0);
    check("t7_active", 64'(active_stage), 64'd0);
    @(negedge clk);
    enable_sequence = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
